// File: rtl/noc_local_injector_pkg.sv
// Shared mesh parameters, injection FIFO entry layout and coordinate helpers
// for the local injector.
package noc_local_injector_pkg;

  localparam int MESH_SIDE   = 4;
  localparam int DATA_WIDTH  = 16;
  localparam int COORD_WIDTH = 3;

  localparam logic [COORD_WIDTH:0] MESH_SIDE_W = (COORD_WIDTH+1)'(MESH_SIDE);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]         data;
    logic [COORD_WIDTH-1:0]        dest_x;
    logic [COORD_WIDTH-1:0]        dest_y;
    logic signed [COORD_WIDTH:0]   s_delta_x;
    logic signed [COORD_WIDTH:0]   s_delta_y;
  } inj_entry_t;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_e;

  // Sign-extend both coordinates one bit, then subtract.
  function automatic logic signed [COORD_WIDTH:0] coord_delta(
    input logic [COORD_WIDTH-1:0] dest,
    input logic [COORD_WIDTH-1:0] own
  );
    return $signed({dest[COORD_WIDTH-1], dest}) - $signed({own[COORD_WIDTH-1], own});
  endfunction

  function automatic logic coord_ok(input logic [COORD_WIDTH-1:0] c);
    return ({1'b0, c} < MESH_SIDE_W);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Generic synchronous FIFO, parameterised on entry type and power-of-two depth.
// Pushes when full and pops when empty are ignored.
module noc_sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wdata,
  input  logic pop,
  output T     rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  T              mem_r [DEPTH];
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == DEPTH_W);
  assign empty     = (count_r == {(AW+1){1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/noc_local_injector.sv
// Mesh-node injection interface: buffers core packets, attaches signed X/Y
// deltas and drives the router LOCAL input. Optional counters: NOC_INJECTOR_STATS_EN.
module noc_local_injector
  import noc_local_injector_pkg::*;
#(
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    core_valid,
  output logic                    core_ready,
  input  logic [DATA_WIDTH-1:0]   core_data,
  input  logic [COORD_WIDTH-1:0]  core_dest_x,
  input  logic [COORD_WIDTH-1:0]  core_dest_y,
  output logic                    net_valid,
  input  logic                    net_ready,
  output logic [DATA_WIDTH-1:0]   net_data,
  output logic [COORD_WIDTH-1:0]  net_dest_x,
  output logic [COORD_WIDTH-1:0]  net_dest_y,
  output logic [COORD_WIDTH:0]    net_s_delta_x,
  output logic [COORD_WIDTH:0]    net_s_delta_y,
`ifdef NOC_INJECTOR_STATS_EN
  output logic [31:0]             stat_injected,
  output logic [31:0]             stat_dropped,
`endif
  output logic                    drop_err
);

  localparam logic [COORD_WIDTH-1:0] OWN_X = COORD_WIDTH'(X_COORD);
  localparam logic [COORD_WIDTH-1:0] OWN_Y = COORD_WIDTH'(Y_COORD);

  inj_entry_t  push_entry_s;
  inj_entry_t  fifo_rdata_s;
  inj_entry_t  out_r;
  out_state_e  state_r;
  out_state_e  state_n_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        push_s;
  logic        bad_dest_s;
  logic        pop_s;
  logic        drop_err_r;

  // core_ready depends only on registered FIFO state, never on net_ready.
  assign core_ready = ~rst & ~fifo_full_s;
  assign push_s     = core_valid & core_ready;
  assign bad_dest_s = ~coord_ok(core_dest_x) | ~coord_ok(core_dest_y);

  // Build the FIFO entry with deltas resolved at push time.
  always_comb begin
    push_entry_s.data      = core_data;
    push_entry_s.dest_x    = core_dest_x;
    push_entry_s.dest_y    = core_dest_y;
    push_entry_s.s_delta_x = coord_delta(core_dest_x, OWN_X);
    push_entry_s.s_delta_y = coord_delta(core_dest_y, OWN_Y);
  end

  noc_sync_fifo #(
    .T     (inj_entry_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s & ~bad_dest_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Output-stage next state and pop decision; reload on accept keeps full rate.
  always_comb begin
    state_n_s = state_r;
    pop_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (!fifo_empty_s) begin
          pop_s     = 1'b1;
          state_n_s = ST_HOLD;
        end else begin
          state_n_s = ST_EMPTY;
        end
      end
      ST_HOLD: begin
        if (net_ready) begin
          if (!fifo_empty_s) begin
            pop_s     = 1'b1;
            state_n_s = ST_HOLD;
          end else begin
            state_n_s = ST_EMPTY;
          end
        end else begin
          state_n_s = ST_HOLD;
        end
      end
      default: begin
        state_n_s = ST_EMPTY;
      end
    endcase
  end

  // Output register, state and drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_EMPTY;
      out_r      <= '0;
      drop_err_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      drop_err_r <= push_s & bad_dest_s;
      if (pop_s) out_r <= fifo_rdata_s;
    end
  end

  assign net_valid     = (state_r == ST_HOLD);
  assign net_data      = out_r.data;
  assign net_dest_x    = out_r.dest_x;
  assign net_dest_y    = out_r.dest_y;
  assign net_s_delta_x = out_r.s_delta_x;
  assign net_s_delta_y = out_r.s_delta_y;
  assign drop_err      = drop_err_r;

`ifdef NOC_INJECTOR_STATS_EN
  logic [31:0] stat_injected_r;
  logic [31:0] stat_dropped_r;

  // Saturating traffic counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_injected_r <= 32'd0;
      stat_dropped_r  <= 32'd0;
    end else begin
      if (net_valid && net_ready && (stat_injected_r != 32'hFFFF_FFFF))
        stat_injected_r <= stat_injected_r + 32'd1;
      if (drop_err_r && (stat_dropped_r != 32'hFFFF_FFFF))
        stat_dropped_r <= stat_dropped_r + 32'd1;
    end
  end

  assign stat_injected = stat_injected_r;
  assign stat_dropped  = stat_dropped_r;
`endif

endmodule

// File: doc/noc_local_injector.md
Name: noc_local_injector

Overview:
- Network interface on the injection side of one mesh node.
- Accepts payload words plus absolute destination coordinates from a local core and buffers them in a FIFO.
- Converts destination into signed X/Y deltas relative to its own node and presents packets on the router LOCAL input with valid/ready.
- One instance per mesh node; its network port connects to that node's local_in.

Parameters:
- X_COORD, 0, own node X coordinate (0..MESH_SIDE-1)
- Y_COORD, 0, own node Y coordinate (0..MESH_SIDE-1)
- FIFO_DEPTH, 4, injection FIFO entries; power of two, >=2

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- core_valid  in  1  core offers a packet
- core_ready  out  1  injector can accept
- core_data  in  DATA_WIDTH  payload
- core_dest_x  in  COORD_WIDTH  absolute destination X
- core_dest_y  in  COORD_WIDTH  absolute destination Y
- net_valid  out  1  packet on router LOCAL input
- net_ready  in  1  router accepts
- net_data  out  DATA_WIDTH  payload
- net_dest_x  out  COORD_WIDTH  destination X, unchanged
- net_dest_y  out  COORD_WIDTH  destination Y, unchanged
- net_s_delta_x  out  COORD_WIDTH+1  signed dest_x - X_COORD
- net_s_delta_y  out  COORD_WIDTH+1  signed dest_y - Y_COORD
- drop_err  out  1  one-cycle pulse: packet dropped (bad destination)

Behaviour:
- Reset: async and active-high. All of the following are cleared: FIFO pointers and count, output register, state, counters.
  - Reset values: net_valid=0, net_data=0, net_dest_x=0, net_dest_y=0, net_s_delta_x=0, net_s_delta_y=0, drop_err=0.
  - core_ready=0 while rst is high; core_ready=1 from the first cycle after release.
- Push handshake: a push occurs when core_valid && core_ready.
  - core_ready = !fifo_full. It is registered-state derived, with no combinational path from net_ready.
- Destination check at push time: a packet with dest_x>=MESH_SIDE or dest_y>=MESH_SIDE is not written to the FIFO.
  - drop_err pulses the next cycle.
  - The core still sees the handshake complete.
- Deltas: computed at push and stored in the FIFO entry.
  - Sign-extend dest and own coordinate to COORD_WIDTH+1, then subtract.
- Self-addressed packets (delta 0,0) are injected normally.
- Output stage: a single register with states EMPTY and HOLD.
  - EMPTY, FIFO non-empty: pop, load the register, go to HOLD; net_valid=1 the next cycle.
  - HOLD, net_ready=1: the transfer completes. If the FIFO is non-empty, pop and reload in the same cycle and stay in HOLD (full throughput). Otherwise go to EMPTY.
  - HOLD, net_ready=0: all net_* outputs are held stable; valid is never withdrawn.
- Latency: push to net_valid is 2 cycles with the FIFO and output stage empty (FIFO write, then register load).
- Simultaneous push and pop with the FIFO full:
  - Push is blocked, because core_ready=0 reflects the registered full state.
  - The pop frees the slot for the next cycle.
- Simultaneous push and pop with the FIFO empty: the pop sees the empty state and pushed data is not bypassed.
- Pointers wrap modulo FIFO_DEPTH. The count is separate, width $clog2(FIFO_DEPTH)+1.
- Reset mid-transfer: packets held in the FIFO and output register are discarded; net_valid drops asynchronously.

Optional Feature:
- Macro: NOC_INJECTOR_STATS_EN.
- When defined, the block adds outputs stat_injected and stat_dropped, each 32 bits.
  - stat_injected increments on each net_valid && net_ready.
  - stat_dropped increments with each drop_err.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- global_params holds: MESH_SIDE, DATA_WIDTH, COORD_WIDTH, and a packed inj_entry_t struct (data, dest_x, dest_y, s_delta_x, s_delta_y).
- Sub-module: noc_sync_fifo, a generic synchronous FIFO parameterised on entry type and depth, exposing full/empty.
- The destination check, delta arithmetic and output FSM stay in the top module.

Test Plan (MESH_SIDE=4, X_COORD=1, Y_COORD=2, FIFO_DEPTH=4):
- Push data=0xA5 to dest (3,0), net_ready=1 -> 2 cycles later net_valid=1, s_delta_x=+2, s_delta_y=-2, data=0xA5, one beat.
- Push dest (1,2) -> injected, s_delta_x=0, s_delta_y=0.
- Push dest (4,1) -> no net_valid, drop_err pulses once, core_ready stays 1; with NOC_INJECTOR_STATS_EN, stat_dropped=1.
- net_ready=0, push 6 packets back-to-back -> 4 in FIFO plus 1 in register; core_ready=0 after 5 accepts; net_* outputs stable.
  - Then raise net_ready -> 5 packets emerge in order on consecutive cycles.
- Continuous push with net_ready=1 -> one packet per cycle sustained, no bubbles after the initial 2-cycle latency.
- Assert rst while net_valid=1 and the FIFO holds 3 entries -> net_valid=0 immediately, and nothing is emitted after release.
